// File: rtl/pcie_tx_lane_striper.sv
// rtl/pcie_tx_lane_striper.sv - PCIe TX lane striper with periodic SKP ordered-set insertion
// Optional per-lane scrambler built when PCIE_TX_STRIPER_SCRAMBLE_EN is defined.
module pcie_tx_lane_striper #(
  parameter int NUM_LANES    = 4,
  parameter int SKP_INTERVAL = 1180
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_LANES-1:0]   lane_enable_i,
  input  logic                   bypass_scrambler_i,
  input  logic [8*NUM_LANES-1:0] data_i,
  input  logic [NUM_LANES-1:0]   data_k_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  output logic [8*NUM_LANES-1:0] lane_symbol_o,
  output logic [NUM_LANES-1:0]   lane_k_o,
  output logic [NUM_LANES-1:0]   lane_valid_o
);
  localparam int               CNT_W    = $clog2(SKP_INTERVAL);
  localparam logic [CNT_W-1:0] SKP_LAST = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [7:0]       COM_SYM  = 8'hBC;
  localparam logic [7:0]       SKP_SYM  = 8'h1C;

  typedef enum logic [2:0] {ST_DATA, ST_SKP0, ST_SKP1, ST_SKP2, ST_SKP3} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       skp_cnt_q, skp_cnt_d;
  logic [8*NUM_LANES-1:0] raw_sym, sym_d, sym_q;
  logic [NUM_LANES-1:0]   raw_k, k_d, k_q, valid_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_DATA;
      skp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      skp_cnt_q <= skp_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    skp_cnt_d = skp_cnt_q;
    case (state_q)
      ST_DATA: begin
        if (skp_cnt_q == SKP_LAST) begin
          state_d   = ST_SKP0;
          skp_cnt_d = '0;
        end else begin
          skp_cnt_d = skp_cnt_q + 1'b1;
        end
      end
      ST_SKP0: state_d = ST_SKP1;
      ST_SKP1: state_d = ST_SKP2;
      ST_SKP2: state_d = ST_SKP3;
      default: state_d = ST_DATA;
    endcase
  end

  // Pre-scramble symbol per lane: data beat or idle in DATA, ordered set otherwise.
  always_comb begin
    data_ready_o = 1'b0;
    raw_sym      = '0;
    raw_k        = '0;
    case (state_q)
      ST_DATA: begin
        data_ready_o = rst_i;
        if (data_valid_i) begin
          raw_sym = data_i;
          raw_k   = data_k_i;
        end
      end
      ST_SKP0: begin
        raw_sym = {NUM_LANES{COM_SYM}};
        raw_k   = '1;
      end
      default: begin
        raw_sym = {NUM_LANES{SKP_SYM}};
        raw_k   = '1;
      end
    endcase
  end

`ifdef PCIE_TX_STRIPER_SCRAMBLE_EN
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;

  logic [NUM_LANES-1:0][15:0] lfsr_q, lfsr_d;
  logic [7:0]                 lane_b;

  // Galois form of x^16+x^5+x^4+x^3+1, advanced one byte time.
  function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int n = 0; n < 8; n++) begin
      r = {r[14:0], 1'b0} ^ (r[15] ? 16'h0039 : 16'h0000);
    end
    return r;
  endfunction

  function automatic logic [7:0] lfsr_mask(input logic [15:0] s);
    return {s[8], s[9], s[10], s[11], s[12], s[13], s[14], s[15]};
  endfunction

  always_comb begin
    lfsr_d = lfsr_q;
    sym_d  = '0;
    k_d    = '0;
    lane_b = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_b = raw_sym[8*i +: 8];
      if (!lane_enable_i[i]) begin
        lfsr_d[i] = LFSR_SEED;
      end else begin
        k_d[i] = raw_k[i];
        if (raw_k[i] && lane_b == COM_SYM) begin
          lfsr_d[i] = LFSR_SEED;
        end else if (!(raw_k[i] && lane_b == SKP_SYM)) begin
          lfsr_d[i] = lfsr_adv8(lfsr_q[i]);
          if (!raw_k[i] && !bypass_scrambler_i) begin
            lane_b = lane_b ^ lfsr_mask(lfsr_q[i]);
          end
        end
        sym_d[8*i +: 8] = lane_b;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lfsr_q <= {NUM_LANES{LFSR_SEED}};
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = bypass_scrambler_i;

  always_comb begin
    sym_d = '0;
    k_d   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_enable_i[i]) begin
        sym_d[8*i +: 8] = raw_sym[8*i +: 8];
        k_d[i]          = raw_k[i];
      end
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sym_q   <= '0;
      k_q     <= '0;
      valid_q <= '0;
    end else begin
      sym_q   <= sym_d;
      k_q     <= k_d;
      valid_q <= lane_enable_i;
    end
  end

  assign lane_symbol_o = sym_q;
  assign lane_k_o      = k_q;
  assign lane_valid_o  = valid_q;

endmodule

// File: tb/tb_pcie_tx_lane_striper.sv
// tb/tb_pcie_tx_lane_striper.sv - directed and scoreboard bench for pcie_tx_lane_striper
// Expected idle bytes follow PCIE_TX_STRIPER_SCRAMBLE_EN.
module tb_pcie_tx_lane_striper;
  localparam int NL = 4;

`ifdef PCIE_TX_STRIPER_SCRAMBLE_EN
  localparam logic [7:0] I0 = 8'hFF, I1 = 8'h17, I2 = 8'hC0, I3 = 8'h14;
`else
  localparam logic [7:0] I0 = 8'h00, I1 = 8'h00, I2 = 8'h00, I3 = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NL-1:0] en;
  logic          byp;
  logic [31:0]   din;
  logic [NL-1:0] dk;
  logic          dv;
  logic          rdy;
  logic [31:0]   sym;
  logic [NL-1:0] k;
  logic [NL-1:0] v;

  int n_pass  = 0;
  int n_total = 0;
  int beats   = 0;
  int cyc     = 0;
  logic        acc;
  logic        stall;
  logic [31:0] sent;

  always #5 clk = ~clk;

  pcie_tx_lane_striper #(.NUM_LANES(NL), .SKP_INTERVAL(16)) dut (
    .clk_i(clk), .rst_i(rst), .lane_enable_i(en), .bypass_scrambler_i(byp),
    .data_i(din), .data_k_i(dk), .data_valid_i(dv), .data_ready_o(rdy),
    .lane_symbol_o(sym), .lane_k_o(k), .lane_valid_o(v)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 4'hF; byp = 1'b0; din = '0; dk = '0; dv = 1'b0;
    repeat (3) step();
    chk("rst_sym", sym, 32'h0);
    chk("rst_k", {28'h0, k}, 32'h0);
    chk("rst_valid", {28'h0, v}, 32'h0);
    chk("rst_ready", {31'h0, rdy}, 32'h0);
    rst = 1'b1;
    #1;
    chk("rel_ready", {31'h0, rdy}, 32'h1);

    // Idle sequence, then SKP ordered set after 16 DATA cycles
    step(); chk("idle0", sym, {4{I0}}); chk("idle0_valid", {28'h0, v}, 32'hF);
    step(); chk("idle1", sym, {4{I1}});
    step(); chk("idle2", sym, {4{I2}});
    step(); chk("idle3", sym, {4{I3}}); chk("idle3_k", {28'h0, k}, 32'h0);
    repeat (11) step();
    chk("cnt15_ready", {31'h0, rdy}, 32'h1);
    step(); chk("skp0_ready", {31'h0, rdy}, 32'h0);
    step(); chk("com_sym", sym, 32'hBCBCBCBC); chk("com_k", {28'h0, k}, 32'hF);
    chk("skp1_ready", {31'h0, rdy}, 32'h0);
    step(); chk("skp_a", sym, 32'h1C1C1C1C); chk("skp_a_k", {28'h0, k}, 32'hF);
    step(); chk("skp_b", sym, 32'h1C1C1C1C);
    step(); chk("skp_c", sym, 32'h1C1C1C1C); chk("skp_c_k", {28'h0, k}, 32'hF);
    chk("post_skp_ready", {31'h0, rdy}, 32'h1);
    step(); chk("post_skp_idle", sym, {4{I0}}); chk("post_skp_k", {28'h0, k}, 32'h0);

    // Two-lane bypass beat, then lane re-enable from seed
    en = 4'b0011; din = 32'hAABBCCDD; dv = 1'b1; byp = 1'b1;
    step(); chk("x2_sym", sym, 32'h0000CCDD); chk("x2_valid", {28'h0, v}, 32'h3);
    chk("x2_k", {28'h0, k}, 32'h0);
    dv = 1'b0; byp = 1'b0;
    step(); chk("x2_idle", sym, {16'h0, I2, I2});
    en = 4'hF;
    step(); chk("reen_idle", sym, {I0, I0, I3, I3}); chk("reen_valid", {28'h0, v}, 32'hF);

    // Reset pulse during SKP1
    do_reset();
    repeat (17) step();
    chk("pre_abort_com", sym, 32'hBCBCBCBC);
    rst = 1'b0;
    step();
    chk("abort_sym", sym, 32'h0); chk("abort_k", {28'h0, k}, 32'h0);
    chk("abort_valid", {28'h0, v}, 32'h0); chk("abort_ready", {31'h0, rdy}, 32'h0);
    rst = 1'b1;
    #1;
    chk("abort_rel_ready", {31'h0, rdy}, 32'h1);
    step(); chk("abort_first_idle", sym, {4{I0}});
    repeat (14) step();
    chk("abort_cnt15_ready", {31'h0, rdy}, 32'h1);
    step(); chk("abort_skp0_ready", {31'h0, rdy}, 32'h0);

    // K characters: COM reseeds, SKP holds, other K advances
    do_reset();
    step(); chk("k_idle0", sym, {4{I0}});
    din = 32'hFB1CBC00; dk = 4'b1110; dv = 1'b1;
    step(); chk("k_beat", sym, {24'hFB1CBC, I1}); chk("k_beat_k", {28'h0, k}, 32'hE);
    dv = 1'b0; dk = '0;
    step(); chk("k_after", sym, {I2, I1, I0, I2});

    // Random beats with back-pressure from SKP insertion
    do_reset();
    byp = 1'b1; dk = '0; dv = 1'b0; sent = '0;
    while (beats < 1000 && cyc < 5000) begin
      if (!dv && $urandom_range(0, 3) != 0) begin
        dv  = 1'b1;
        din = $urandom;
      end
      acc   = dv && rdy;
      stall = !rdy;
      sent  = din;
      step();
      if (acc) begin
        chk("sb_data", sym, sent);
        beats++;
        dv = 1'b0;
      end else if (stall) begin
        chk("sb_skp_k", {28'h0, k}, 32'hF);
      end else begin
        chk("sb_idle", sym, 32'h0);
      end
      cyc++;
    end
    chk("sb_beats", beats, 1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
